icache_ibus_responder: RTL and testbench

//  Slave end of cpu_ibus_if: direct-mapped, read-only instruction cache between the CPU fetch stage
//  and a 32-bit burst memory read port. 2-stage pipeline: stage 1 indexes tag/data arrays, stage 2

---
 rtl/icache_ibus_responder.sv | 150 +++++++++++++++
 tb/tb_icache_ibus_responder.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/icache_ibus_responder.sv
// rtl/icache_ibus_responder.sv - direct-mapped read-only instruction cache, ibus slave with burst refill
module icache_ibus_responder #(
    parameter int LINE_BYTES = 32,
    parameter int SETS       = 128
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        ibus_read_i,
    input  logic [31:0] ibus_address_i,
    input  logic        ibus_flush_1_i,
    input  logic        ibus_flush_2_i,
    output logic        ibus_stall_o,
    output logic [63:0] ibus_rddata_o,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_ack_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_rlast_i
);
    localparam int OFF_W  = $clog2(LINE_BYTES);
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = 32 - OFF_W - IDX_W;
    localparam int BEATS  = LINE_BYTES / 4;
    localparam int CNT_W  = $clog2(BEATS) + 1;
    localparam int LINE_W = LINE_BYTES * 8;
    localparam int LB_W   = OFF_W + 3;

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_REFILL, S_WRITE, S_RESP} state_t;

    state_t             state_q, state_d;
    logic               slot_valid_q;
    logic [31:0]        slot_addr_q;
    logic [31:0]        mem_addr_q;
    logic [CNT_W-1:0]   beat_q;
    logic               killed_q;
    logic [SETS-1:0]    valid_q;
    logic [TAG_W-1:0]   tag_q  [SETS];
    logic [LINE_W-1:0]  data_q [SETS];
    logic [LINE_W-1:0]  line_q;

    logic [IDX_W-1:0]   slot_idx;
    logic [TAG_W-1:0]   slot_tag;
    logic [OFF_W-1:0]   slot_off;
    logic [LB_W-1:0]    rd_base;
    logic [LB_W-1:0]    wr_base;
    logic [63:0]        data_rd;
    logic [63:0]        line_rd;
    logic               hit;
    logic               accept;
    logic               retire;
    logic               beat_wr;

    assign slot_idx = slot_addr_q[OFF_W +: IDX_W];
    assign slot_tag = slot_addr_q[31 -: TAG_W];
    assign slot_off = slot_addr_q[OFF_W-1:0];
    // Bit position of the addressed 64-bit word inside a line.
    assign rd_base  = {slot_off & ~OFF_W'(7), 3'b000};
    assign wr_base  = {beat_q[CNT_W-2:0], 5'b00000};
    assign data_rd  = data_q[slot_idx][rd_base +: 64];
    assign line_rd  = line_q[rd_base +: 64];
    assign hit      = valid_q[slot_idx] && (tag_q[slot_idx] == slot_tag);
    assign accept   = ibus_read_i && !ibus_stall_o && !ibus_flush_1_i;
    assign beat_wr  = (state_q == S_REFILL) && mem_rvalid_i && !beat_q[CNT_W-1];
    assign retire   = ((state_q == S_IDLE) && (hit || ibus_flush_2_i))
                   || ((state_q == S_REQ) && ibus_flush_2_i && !mem_ack_i)
                   || (state_q == S_RESP)
                   || ((state_q == S_WRITE) && (killed_q || ibus_flush_2_i));
    assign mem_addr_o = mem_addr_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (slot_valid_q && !hit && !ibus_flush_2_i) state_d = S_REQ;
            S_REQ:    if (mem_ack_i) state_d = S_REFILL;
                      else if (ibus_flush_2_i) state_d = S_IDLE;
            S_REFILL: if (mem_rvalid_i && mem_rlast_i) state_d = S_WRITE;
            S_WRITE:  state_d = (killed_q || ibus_flush_2_i) ? S_IDLE : S_RESP;
            S_RESP:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ibus_stall_o  = 1'b0;
        ibus_rddata_o = 64'd0;
        mem_req_o     = 1'b0;
        case (state_q)
            S_IDLE: begin
                ibus_stall_o = slot_valid_q && !hit && !ibus_flush_2_i;
                if (slot_valid_q && hit && !ibus_flush_2_i) ibus_rddata_o = data_rd;
            end
            S_REQ: begin
                ibus_stall_o = 1'b1;
                mem_req_o    = 1'b1;
            end
            S_REFILL, S_WRITE: ibus_stall_o = 1'b1;
            S_RESP:  ibus_rddata_o = line_rd;
            default: ibus_stall_o = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            slot_valid_q <= 1'b0;
            slot_addr_q  <= 32'd0;
            mem_addr_q   <= 32'd0;
            beat_q       <= '0;
            killed_q     <= 1'b0;
            valid_q      <= '0;
        end else begin
            if (accept) begin
                slot_valid_q <= 1'b1;
                slot_addr_q  <= ibus_address_i;
            end else if (retire) begin
                slot_valid_q <= 1'b0;
            end
            if ((state_q == S_IDLE) && (state_d == S_REQ))
                mem_addr_q <= {slot_addr_q[31:OFF_W], {OFF_W{1'b0}}};
            // Counter saturates after a full line so surplus beats are dropped.
            if ((state_q == S_REQ) && mem_ack_i)
                beat_q <= '0;
            else if (beat_wr)
                beat_q <= beat_q + 1'b1;
            if (state_q == S_WRITE)
                killed_q <= 1'b0;
            else if (ibus_flush_2_i && (((state_q == S_REQ) && mem_ack_i) || (state_q == S_REFILL)))
                killed_q <= 1'b1;
            if (state_q == S_WRITE)
                valid_q[slot_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (beat_wr)
            line_q[wr_base +: 32] <= mem_rdata_i;
        if (state_q == S_WRITE) begin
            tag_q[slot_idx]  <= slot_tag;
            data_q[slot_idx] <= line_q;
        end
    end
endmodule

// File: tb/tb_icache_ibus_responder.sv
// tb/tb_icache_ibus_responder.sv - directed self-checking bench for icache_ibus_responder
module tb_icache_ibus_responder;
    logic        clk = 1'b0;
    logic        rst;
    logic        read;
    logic [31:0] addr;
    logic        f1, f2;
    logic        ack, rvalid, rlast;
    logic [31:0] rdata;
    logic        stall, mem_req;
    logic [63:0] rddata;
    logic [31:0] mem_addr;
    int          checks = 0;
    int          failures = 0;

    icache_ibus_responder #(.LINE_BYTES(32), .SETS(128)) dut (
        .clk_i(clk), .rst_i(rst),
        .ibus_read_i(read), .ibus_address_i(addr),
        .ibus_flush_1_i(f1), .ibus_flush_2_i(f2),
        .ibus_stall_o(stall), .ibus_rddata_o(rddata),
        .mem_req_o(mem_req), .mem_addr_o(mem_addr),
        .mem_ack_i(ack), .mem_rvalid_i(rvalid),
        .mem_rdata_i(rdata), .mem_rlast_i(rlast)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Entered in the miss cycle; returns in the cycle after WRITE (RESP or IDLE).
    task automatic do_refill(input logic [31:0] exp_addr, input logic [31:0] seed, input int kill_beat);
        int n = 0;
        while (!mem_req && n < 10) begin
            cyc();
            #1;
            n++;
        end
        chk("req_seen", {63'd0, mem_req}, 64'd1);
        chk("req_addr", {32'd0, mem_addr}, {32'd0, exp_addr});
        chk("req_stall", {63'd0, stall}, 64'd1);
        ack = 1'b1;
        cyc();
        ack = 1'b0;
        for (int i = 0; i < 8; i++) begin
            rvalid = 1'b1;
            rdata  = seed * (i + 1);
            rlast  = (i == 7);
            if (i == kill_beat) begin
                f1 = 1'b1; f2 = 1'b1; read = 1'b0;
            end
            cyc();
            f1 = 1'b0; f2 = 1'b0;
        end
        rvalid = 1'b0; rlast = 1'b0;
        #1;
        chk("write_stall", {63'd0, stall}, 64'd1);
        cyc();
        #1;
    endtask

    initial begin
        rst = 1'b1; read = 1'b0; addr = 32'd0; f1 = 1'b0; f2 = 1'b0;
        ack = 1'b0; rvalid = 1'b0; rlast = 1'b0; rdata = 32'd0;
        repeat (3) cyc();
        rst = 1'b0;
        #1;
        chk("rst_stall", {63'd0, stall}, 64'd0);
        chk("rst_rddata", rddata, 64'd0);
        chk("rst_req", {63'd0, mem_req}, 64'd0);
        chk("rst_addr", {32'd0, mem_addr}, 64'd0);

        // cold miss
        read = 1'b1; addr = 32'h0000_1008;
        chk("idle_stall", {63'd0, stall}, 64'd0);
        cyc(); #1;
        chk("miss_stall", {63'd0, stall}, 64'd1);
        chk("miss_noreq", {63'd0, mem_req}, 64'd0);
        do_refill(32'h0000_1000, 32'h11, -1);
        chk("cold_rddata", rddata, 64'h0000_0044_0000_0033);
        chk("cold_stall", {63'd0, stall}, 64'd0);

        // back-to-back hits
        addr = 32'h0000_1000;
        cyc(); #1;
        chk("hit0_rddata", rddata, 64'h0000_0022_0000_0011);
        chk("hit0_stall", {63'd0, stall}, 64'd0);
        addr = 32'h0000_1008;
        cyc(); #1;
        chk("hit1_rddata", rddata, 64'h0000_0044_0000_0033);
        chk("hit1_req", {63'd0, mem_req}, 64'd0);
        addr = 32'h0000_1010;
        cyc(); #1;
        chk("hit2_rddata", rddata, 64'h0000_0066_0000_0055);
        chk("hit2_stall", {63'd0, stall}, 64'd0);
        read = 1'b0;
        cyc(); #1;
        chk("empty_stall", {63'd0, stall}, 64'd0);
        chk("empty_req", {63'd0, mem_req}, 64'd0);

        // conflict miss on the same set
        read = 1'b1; addr = 32'h0000_2008;
        cyc(); #1;
        chk("conf_stall", {63'd0, stall}, 64'd1);
        do_refill(32'h0000_2000, 32'h101, -1);
        chk("conf_rddata", rddata, 64'h0000_0404_0000_0303);
        addr = 32'h0000_1008;
        cyc(); #1;
        chk("evict_stall", {63'd0, stall}, 64'd1);
        do_refill(32'h0000_1000, 32'h11, -1);
        chk("evict_rddata", rddata, 64'h0000_0044_0000_0033);
        read = 1'b0;
        cyc(); #1;

        // flush_2 during REFILL beat 3
        read = 1'b1; addr = 32'h0000_2000;
        cyc(); #1;
        chk("kr_stall", {63'd0, stall}, 64'd1);
        do_refill(32'h0000_2000, 32'h101, 3);
        chk("kr_idle_stall", {63'd0, stall}, 64'd0);
        chk("kr_rddata", rddata, 64'd0);
        read = 1'b1; addr = 32'h0000_2008;
        cyc(); #1;
        chk("kr_hit_rddata", rddata, 64'h0000_0404_0000_0303);
        chk("kr_hit_stall", {63'd0, stall}, 64'd0);
        chk("kr_hit_req", {63'd0, mem_req}, 64'd0);
        read = 1'b0;

        // flush_2 while REQ without ack
        read = 1'b1; addr = 32'h0000_4008;
        cyc(); #1;
        chk("kq_miss", {63'd0, stall}, 64'd1);
        cyc(); #1;
        chk("kq_req", {63'd0, mem_req}, 64'd1);
        f1 = 1'b1; f2 = 1'b1; read = 1'b0;
        cyc();
        f1 = 1'b0; f2 = 1'b0;
        #1;
        chk("kq_req_drop", {63'd0, mem_req}, 64'd0);
        chk("kq_stall", {63'd0, stall}, 64'd0);
        read = 1'b1; addr = 32'h0000_2010;
        cyc(); #1;
        chk("kq_next_rddata", rddata, 64'h0000_0606_0000_0505);
        chk("kq_next_stall", {63'd0, stall}, 64'd0);
        read = 1'b0;

        // reset in the middle of a refill
        read = 1'b1; addr = 32'h0000_1008;
        cyc(); #1;
        cyc(); #1;
        chk("rr_req", {63'd0, mem_req}, 64'd1);
        ack = 1'b1;
        cyc();
        ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rvalid = 1'b1; rdata = 32'hA0 + i; rlast = 1'b0;
            cyc();
        end
        rst = 1'b1; rdata = 32'hA3;
        cyc();
        rst = 1'b0; read = 1'b0;
        #1;
        chk("rr_stall", {63'd0, stall}, 64'd0);
        chk("rr_mreq", {63'd0, mem_req}, 64'd0);
        chk("rr_maddr", {32'd0, mem_addr}, 64'd0);
        chk("rr_rddata", rddata, 64'd0);
        for (int i = 4; i < 8; i++) begin
            rdata = 32'hA0 + i; rlast = (i == 7);
            cyc();
        end
        rvalid = 1'b0; rlast = 1'b0;
        #1;
        chk("rr_ignored_req", {63'd0, mem_req}, 64'd0);
        read = 1'b1; addr = 32'h0000_2008;
        cyc(); #1;
        chk("rr_remiss", {63'd0, stall}, 64'd1);
        chk("rr_remiss_data", rddata, 64'd0);
        cyc(); #1;
        chk("rr_rereq", {63'd0, mem_req}, 64'd1);
        chk("rr_readdr", {32'd0, mem_addr}, 64'h0000_2000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
